// File: rtl/clock_2.sv
// Hours/minutes/seconds clock with a clock-enable prescaler, BCD time load and
// active-low seven-segment outputs for all six digits.
module clock_2 #(
  parameter int hrs_tc_p  = 11,
  parameter int mins_tc_p = 59,
  parameter int secs_tc_p = 59,
  parameter int clk_tc_p  = 49999999
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        nLoadNow_i,
  input  logic        manageZeroHour_i,
  input  logic        useBlanker_i,
  input  logic [17:2] switch_i,
  output logic [6:0]  hrs_msb_o,
  output logic [6:0]  hrs_lsb_o,
  output logic [6:0]  mins_msb_o,
  output logic [6:0]  mins_lsb_o,
  output logic [6:0]  secs_msb_o,
  output logic [6:0]  secs_lsb_o
);

  localparam int HrsW   = (hrs_tc_p  > 0) ? $clog2(hrs_tc_p + 1)  : 1;
  localparam int MinsW  = (mins_tc_p > 0) ? $clog2(mins_tc_p + 1) : 1;
  localparam int SecsW  = (secs_tc_p > 0) ? $clog2(secs_tc_p + 1) : 1;
  localparam int PrescW = (clk_tc_p  > 0) ? $clog2(clk_tc_p + 1)  : 1;

  logic [HrsW-1:0]   hrs;
  logic [MinsW-1:0]  mins;
  logic [SecsW-1:0]  secs;
  logic [PrescW-1:0] presc;
  logic              tick;
  logic              secsWrap;
  logic              minsWrap;
  logic              hrsWrap;
  int                loadHrs;
  int                loadMins;
  int                dispHrs;
  int                hrsTens;

  function automatic logic [6:0] segOf(input int d);
    case (d)
      0: segOf = 7'b1000000;
      1: segOf = 7'b1111001;
      2: segOf = 7'b0100100;
      3: segOf = 7'b0110000;
      4: segOf = 7'b0011001;
      5: segOf = 7'b0010010;
      6: segOf = 7'b0000010;
      7: segOf = 7'b1111000;
      8: segOf = 7'b0000000;
      9: segOf = 7'b0010000;
      default: segOf = 7'b1111111;
    endcase
  endfunction

  assign tick     = (presc == PrescW'(clk_tc_p));
  assign secsWrap = (secs == SecsW'(secs_tc_p));
  assign minsWrap = (mins == MinsW'(mins_tc_p));
  assign hrsWrap  = (hrs == HrsW'(hrs_tc_p));

  // BCD load decode: bad digits or out-of-range values collapse the field to 0,
  // so a load can never put a counter beyond its terminal count.
  always_comb begin
    loadHrs  = int'(switch_i[17:14]) * 10 + int'(switch_i[13:10]);
    loadMins = int'(switch_i[9:6]) * 10 + int'(switch_i[5:2]);
    if (switch_i[17:14] > 4'd9 || switch_i[13:10] > 4'd9)
      loadHrs = 0;
    else if (manageZeroHour_i && loadHrs == hrs_tc_p + 1)
      loadHrs = 0;
    if (loadHrs > hrs_tc_p)
      loadHrs = 0;
    if (switch_i[9:6] > 4'd9 || switch_i[5:2] > 4'd9 || loadMins > mins_tc_p)
      loadMins = 0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      presc <= '0;
      secs  <= '0;
      mins  <= '0;
      hrs   <= '0;
    end else if (!nLoadNow_i) begin
      presc <= '0;
      secs  <= '0;
      mins  <= MinsW'(loadMins);
      hrs   <= HrsW'(loadHrs);
    end else begin
      presc <= tick ? '0 : presc + PrescW'(1);
      if (tick) begin
        if (secsWrap) begin
          secs <= '0;
          if (minsWrap) begin
            mins <= '0;
            hrs  <= hrsWrap ? '0 : hrs + HrsW'(1);
          end else begin
            mins <= mins + MinsW'(1);
          end
        end else begin
          secs <= secs + SecsW'(1);
        end
      end
    end
  end

  // Hour 0 shows as hrs_tc_p+1 in 12-hour style; mode inputs act combinationally.
  always_comb begin
    dispHrs    = (manageZeroHour_i && hrs == '0) ? hrs_tc_p + 1 : int'(hrs);
    hrsTens    = dispHrs / 10;
    hrs_msb_o  = (useBlanker_i && hrsTens == 0) ? 7'b1111111 : segOf(hrsTens);
    hrs_lsb_o  = segOf(dispHrs % 10);
    mins_msb_o = segOf(int'(mins) / 10);
    mins_lsb_o = segOf(int'(mins) % 10);
    secs_msb_o = segOf(int'(secs) / 10);
    secs_lsb_o = segOf(int'(secs) % 10);
  end

endmodule

// File: tb/tb_clock_2.sv
// Bench for clock_2: directed scenarios plus randomized load/reset/mode traffic,
// all checked against a time-of-day model using whole-second arithmetic.
module tb_clock_2;

  localparam int HTC = 11;
  localparam int MTC = 59;
  localparam int STC = 1;
  localparam int CTC = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        nLoadNow;
  logic        manageZeroHour;
  logic        useBlanker;
  logic [17:2] sw;
  logic [6:0]  hrsMsb, hrsLsb, minsMsb, minsLsb, secsMsb, secsLsb;
  logic [41:0] dutVec;

  int vectors = 0;
  int miscompares = 0;
  logic [41:0] expQ[$];

  // model state: plain integers for time of day and prescaler phase
  int mH = 0, mM = 0, mS = 0, mP = 0;

  logic [6:0] segTab [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000};
  logic [6:0] s0, s1, s2, s5, s9;
  localparam logic [6:0] BLANK = 7'b1111111;

  always #5 clk = ~clk;

  clock_2 #(
    .hrs_tc_p(HTC), .mins_tc_p(MTC), .secs_tc_p(STC), .clk_tc_p(CTC)
  ) dut (
    .clk_i(clk), .rst_i(rst), .nLoadNow_i(nLoadNow),
    .manageZeroHour_i(manageZeroHour), .useBlanker_i(useBlanker),
    .switch_i(sw),
    .hrs_msb_o(hrsMsb), .hrs_lsb_o(hrsLsb),
    .mins_msb_o(minsMsb), .mins_lsb_o(minsLsb),
    .secs_msb_o(secsMsb), .secs_lsb_o(secsLsb)
  );

  assign dutVec = {hrsMsb, hrsLsb, minsMsb, minsLsb, secsMsb, secsLsb};

  function automatic logic [6:0] segOf(input int d);
    if (d >= 0 && d <= 9) return segTab[d];
    return BLANK;
  endfunction

  function automatic logic [41:0] modelDisplay();
    int dh;
    logic [6:0] hm;
    dh = (manageZeroHour && mH == 0) ? HTC + 1 : mH;
    hm = (useBlanker && dh / 10 == 0) ? BLANK : segOf(dh / 10);
    return {hm, segOf(dh % 10), segOf(mM / 10), segOf(mM % 10),
            segOf(mS / 10), segOf(mS % 10)};
  endfunction

  function automatic int bcdField(input logic [3:0] t, input logic [3:0] o);
    if (t > 4'd9 || o > 4'd9) return -1;
    return int'(t) * 10 + int'(o);
  endfunction

  // one clock edge of the time-of-day model, using the inputs present at the edge
  task automatic modelClock();
    int hv, mv, total;
    if (rst) begin
      mH = 0; mM = 0; mS = 0; mP = 0;
    end else if (!nLoadNow) begin
      hv = bcdField(sw[17:14], sw[13:10]);
      mv = bcdField(sw[9:6], sw[5:2]);
      if (manageZeroHour && hv == HTC + 1) hv = 0;
      if (hv < 0 || hv > HTC) hv = 0;
      if (mv < 0 || mv > MTC) mv = 0;
      mH = hv; mM = mv; mS = 0; mP = 0;
    end else if (mP == CTC) begin
      mP = 0;
      total = ((mH * (MTC + 1) + mM) * (STC + 1) + mS + 1) % ((HTC + 1) * (MTC + 1) * (STC + 1));
      mS = total % (STC + 1);
      total = total / (STC + 1);
      mM = total % (MTC + 1);
      mH = total / (MTC + 1);
    end else begin
      mP = mP + 1;
    end
  endtask

  task automatic checkVal(input string tag, input logic [41:0] got, input logic [41:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    modelClock();
    #1;
    expQ.push_back(modelDisplay());
    checkVal(tag, dutVec, expQ.pop_front());
  endtask

  task automatic loadBcd(input logic [15:0] v);
    sw = v;
    nLoadNow = 1'b0;
    step("load");
    nLoadNow = 1'b1;
  endtask

  initial begin
    s0 = segTab[0]; s1 = segTab[1]; s2 = segTab[2]; s5 = segTab[5]; s9 = segTab[9];
    rst = 1'b1; nLoadNow = 1'b1; manageZeroHour = 1'b0; useBlanker = 1'b0; sw = '0;
    step("reset");
    step("reset");
    rst = 1'b0;
    checkVal("reset_00_00_00", dutVec, {s0, s0, s0, s0, s0, s0});

    manageZeroHour = 1'b1;
    loadBcd(16'h1259);
    checkVal("load_12_59_00", dutVec, {s1, s2, s5, s9, s0, s0});
    manageZeroHour = 1'b0;
    #1;
    checkVal("raw_hour_zero", dutVec, {s0, s0, s5, s9, s0, s0});
    manageZeroHour = 1'b1;
    step("run"); step("run");
    checkVal("run_12_59_01", dutVec, {s1, s2, s5, s9, s0, s1});
    useBlanker = 1'b1;
    step("run"); step("run");
    checkVal("roll_blanked", dutVec, {BLANK, s1, s0, s0, s0, s0});
    useBlanker = 1'b0;
    #1;
    checkVal("roll_unblanked", dutVec, {s0, s1, s0, s0, s0, s0});

    loadBcd(16'h1159);
    repeat (4) step("run");
    checkVal("hour_wrap_12", dutVec, {s1, s2, s0, s0, s0, s0});

    loadBcd(16'h1345);
    checkVal("bad_hours_13", dutVec, {s1, s2, {segTab[4]}, s5, s0, s0});
    loadBcd(16'h1060);
    checkVal("bad_mins_60", dutVec, {s1, s0, s0, s0, s0, s0});
    loadBcd(16'h0A30);
    manageZeroHour = 1'b0;
    loadBcd(16'h1200);
    manageZeroHour = 1'b1;
    step("run");
    rst = 1'b1; nLoadNow = 1'b0; sw = 16'h1159; useBlanker = 1'b1;
    step("rst_vs_load");
    rst = 1'b0; nLoadNow = 1'b1;
    checkVal("reset_wins_12", dutVec, {s1, s2, s0, s0, s0, s0});

    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      nLoadNow = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 31) == 0) manageZeroHour = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 31) == 0) useBlanker = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 3) == 0) begin
        sw = 16'($urandom);
      end else begin
        automatic int h = $urandom_range(0, 13);
        automatic int m = $urandom_range(0, 63);
        sw = {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
      end
      step("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
